// File: rtl/main_memory.sv
// rtl/main_memory.sv - fixed-latency main memory with block read, block write-back and word write-through
module main_memory #(
    parameter int LATENCY = 4,
    parameter int WORDS   = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memReq,
    input  logic         isMemRead,
    input  logic         isBlockWrite,
    input  logic [9:0]   memAddress,
    input  logic [127:0] memWriteData,
    output logic [127:0] memReadData,
    output logic         busy,
    output logic         done,
    output logic [15:0]  txnCount
);
    localparam int         AW   = $clog2(WORDS);
    localparam logic [3:0] LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state;
    state_t         state_next;
    logic [3:0]     count;
    logic           cap_read;
    logic           cap_block;
    logic [9:0]     cap_addr;
    logic [127:0]   cap_data;
    logic           commit;
    logic [AW-1:0]  word_idx;
    logic [AW-1:0]  blk_idx [4];
    logic [127:0]   blk_rdata;
    logic           unused_addr;

    // Each physical word holds (value XOR index): the all-zero power-up image
    // therefore reads back as mem[i] = i without any initialisation sequence.
    logic [31:0]    mem_phys [WORDS] = '{default: '0};

    function automatic logic [31:0] idx_word(input logic [AW-1:0] i);
        return 32'(i);
    endfunction

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // next-state decode and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (memReq) state_next = WAIT;
            WAIT: begin
                busy = 1'b1;
                if (count == 4'd0) state_next = RESP;
            end
            RESP: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // the captured operation takes effect on the edge that enters RESP
    assign commit      = (state == WAIT) && (count == 4'd0) && !reset;
    assign word_idx    = cap_addr[AW+1:2];
    assign unused_addr = ^cap_addr[1:0];

    // indices of the four words of the captured block and their logical contents
    always_comb begin
        blk_rdata = '0;
        for (int k = 0; k < 4; k++) begin
            blk_idx[k] = {cap_addr[AW+1:4], 2'(k)};
            blk_rdata[127-32*k -: 32] = mem_phys[blk_idx[k]] ^ idx_word(blk_idx[k]);
        end
    end

    // request capture, latency counter, read-data register and completion counter
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= 4'd0;
            memReadData <= '0;
            txnCount    <= 16'd0;
            cap_read    <= 1'b0;
            cap_block   <= 1'b0;
            cap_addr    <= '0;
            cap_data    <= '0;
        end else begin
            case (state)
                IDLE: if (memReq) begin
                    cap_read  <= isMemRead;
                    cap_block <= isBlockWrite;
                    cap_addr  <= memAddress;
                    cap_data  <= memWriteData;
                    count     <= LOAD;
                end
                WAIT: if (count != 4'd0) begin
                    count <= count - 4'd1;
                end else begin
                    txnCount <= txnCount + 16'd1;
                    if (cap_read) memReadData <= blk_rdata;
                end
                default: ;
            endcase
        end
    end

    // storage writes; kept out of reset so contents survive it
    always_ff @(posedge clk) begin
        if (commit && !cap_read) begin
            if (cap_block) begin
                mem_phys[blk_idx[0]] <= cap_data[127:96] ^ idx_word(blk_idx[0]);
                mem_phys[blk_idx[1]] <= cap_data[95:64]  ^ idx_word(blk_idx[1]);
                mem_phys[blk_idx[2]] <= cap_data[63:32]  ^ idx_word(blk_idx[2]);
                mem_phys[blk_idx[3]] <= cap_data[31:0]   ^ idx_word(blk_idx[3]);
            end else begin
                mem_phys[word_idx] <= cap_data[31:0] ^ idx_word(word_idx);
            end
        end
    end
endmodule

// File: tb/tb_main_memory.sv
// tb/tb_main_memory.sv - self-checking bench for main_memory
module tb_main_memory;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         memReq, isMemRead, isBlockWrite;
    logic [9:0]   memAddress;
    logic [127:0] memWriteData;
    logic [127:0] memReadData;
    logic         busy, done;
    logic [15:0]  txnCount;

    logic         req1, rd1, blk1;
    logic [9:0]   addr1;
    logic [127:0] wd1, rdata1;
    logic         busy1, done1;
    logic [15:0]  txn1;

    int checks = 0;
    int errors = 0;

    logic [31:0]  mref [256];
    logic [127:0] mrd;
    logic [15:0]  mtxn;

    typedef struct {
        logic         rd;
        logic         blk;
        logic [9:0]   addr;
        logic [127:0] wd;
        logic [127:0] exp_rd;
        logic [15:0]  exp_txn;
    } vec_t;
    vec_t vecs [7];

    main_memory #(.LATENCY(LAT), .WORDS(256)) dut (
        .clk(clk), .reset(reset), .memReq(memReq), .isMemRead(isMemRead),
        .isBlockWrite(isBlockWrite), .memAddress(memAddress), .memWriteData(memWriteData),
        .memReadData(memReadData), .busy(busy), .done(done), .txnCount(txnCount)
    );

    main_memory #(.LATENCY(1), .WORDS(256)) dut1 (
        .clk(clk), .reset(reset), .memReq(req1), .isMemRead(rd1),
        .isBlockWrite(blk1), .memAddress(addr1), .memWriteData(wd1),
        .memReadData(rdata1), .busy(busy1), .done(done1), .txnCount(txn1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_block(input logic [9:0] a);
        return {mref[{a[9:4], 2'd0}], mref[{a[9:4], 2'd1}], mref[{a[9:4], 2'd2}], mref[{a[9:4], 2'd3}]};
    endfunction

    function automatic void model_apply(input logic rd, input logic blk, input logic [9:0] a,
                                        input logic [127:0] wd);
        if (rd) begin
            mrd = model_block(a);
        end else if (blk) begin
            mref[{a[9:4], 2'd0}] = wd[127:96];
            mref[{a[9:4], 2'd1}] = wd[95:64];
            mref[{a[9:4], 2'd2}] = wd[63:32];
            mref[{a[9:4], 2'd3}] = wd[31:0];
        end else begin
            mref[a[9:2]] = wd[31:0];
        end
        mtxn = mtxn + 16'd1;
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge, idle again.
    task automatic do_txn(input logic rd, input logic blk, input logic [9:0] a, input logic [127:0] wd,
                          input string tag, output logic [127:0] rdo, output logic [15:0] tco);
        int cyc;
        memReq       = 1'b1;
        isMemRead    = rd;
        isBlockWrite = blk;
        memAddress   = a;
        memWriteData = wd;
        @(negedge clk);
        memReq       = 1'b0;
        memAddress   = 10'($urandom);
        memWriteData = {$urandom, $urandom, $urandom, $urandom};
        chk1({tag, " busy_after_capture"}, busy, 1'b1);
        chk1({tag, " no_early_done"}, done, 1'b0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done_latency"}, 128'(cyc), 128'(LAT));
        rdo = memReadData;
        tco = txnCount;
        @(negedge clk);
        chk1({tag, " done_one_cycle"}, done, 1'b0);
        chk1({tag, " idle_after_resp"}, busy, 1'b0);
    endtask

    initial begin
        logic [127:0] rdo;
        logic [15:0]  tco;
        logic         seen;
        logic         rd, blk;
        logic [9:0]   a;
        logic [127:0] wd;

        for (int i = 0; i < 256; i++) mref[i] = 32'(i);
        mrd  = '0;
        mtxn = 16'd0;

        vecs[0] = '{1'b1, 1'b0, 10'h040, 128'h0, {32'd16, 32'd17, 32'd18, 32'd19}, 16'd1};
        vecs[1] = '{1'b0, 1'b0, 10'h044, {96'hFFFF_0000_1234, 32'hDEADBEEF},
                    {32'd16, 32'd17, 32'd18, 32'd19}, 16'd2};
        vecs[2] = '{1'b1, 1'b0, 10'h04C, 128'h0, {32'd16, 32'hDEADBEEF, 32'd18, 32'd19}, 16'd3};
        vecs[3] = '{1'b0, 1'b1, 10'h3FC, {32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004},
                    {32'd16, 32'hDEADBEEF, 32'd18, 32'd19}, 16'd4};
        vecs[4] = '{1'b1, 1'b0, 10'h3F0, 128'h0,
                    {32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004}, 16'd5};
        vecs[5] = '{1'b0, 1'b0, 10'h007, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h00000055},
                    {32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004}, 16'd6};
        vecs[6] = '{1'b1, 1'b0, 10'h005, 128'h0, {32'd0, 32'h55, 32'd2, 32'd3}, 16'd7};

        req1 = 1'b0; rd1 = 1'b1; blk1 = 1'b0; addr1 = '0; wd1 = '0;

        // reset with a request pending: reset must win
        reset = 1'b1; memReq = 1'b1; isMemRead = 1'b1; isBlockWrite = 1'b0;
        memAddress = 10'h040; memWriteData = '0;
        repeat (3) @(negedge clk);
        chk1("reset busy", busy, 1'b0);
        chk1("reset done", done, 1'b0);
        chk("reset rdata", memReadData, 128'h0);
        chk("reset txn", 128'(txnCount), 128'h0);
        reset = 1'b0; memReq = 1'b0;
        @(negedge clk);

        // word write aborted by reset while in WAIT
        memReq = 1'b1; isMemRead = 1'b0; isBlockWrite = 1'b0;
        memAddress = 10'h000; memWriteData = {96'h0, 32'h12345678};
        @(negedge clk);
        memReq = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk1("abort busy", busy, 1'b0);
        chk1("abort done", done, 1'b0);
        chk("abort txn", 128'(txnCount), 128'h0);
        seen = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk1("abort no late done", seen, 1'b0);
        do_txn(1'b1, 1'b0, 10'h000, '0, "abort_read", rdo, tco);
        model_apply(1'b1, 1'b0, 10'h000, '0);
        chk("abort read data", rdo, {32'd0, 32'd1, 32'd2, 32'd3});
        chk("abort read txn", 128'(tco), 128'd1);

        // table-driven directed vectors from a fresh reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mrd = '0; mtxn = 16'd0;
        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i].rd, vecs[i].blk, vecs[i].addr, vecs[i].wd, $sformatf("vec%0d", i), rdo, tco);
            model_apply(vecs[i].rd, vecs[i].blk, vecs[i].addr, vecs[i].wd);
            chk($sformatf("vec%0d rdata", i), rdo, vecs[i].exp_rd);
            chk($sformatf("vec%0d txn", i), 128'(tco), 128'(vecs[i].exp_txn));
        end

        // storage survives reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mrd = '0; mtxn = 16'd0;
        do_txn(1'b1, 1'b0, 10'h040, '0, "post_reset_read", rdo, tco);
        model_apply(1'b1, 1'b0, 10'h040, '0);
        chk("post_reset rdata", rdo, {32'd16, 32'hDEADBEEF, 32'd18, 32'd19});

        // memReq held high: slots follow a WAIT*LAT, RESP, IDLE cycle
        memReq = 1'b1; isMemRead = 1'b1; isBlockWrite = 1'b0; memAddress = 10'h3F0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 9) memReq = 1'b0;
            chk1($sformatf("held_req done k=%0d", k), done, (k % (LAT + 2)) == LAT);
            chk1($sformatf("held_req busy k=%0d", k), busy, (k % (LAT + 2)) <= LAT);
        end
        model_apply(1'b1, 1'b0, 10'h3F0, '0);
        model_apply(1'b1, 1'b0, 10'h3F0, '0);
        chk("held_req rdata", memReadData, mrd);
        chk("held_req txn", 128'(txnCount), 128'(mtxn));

        // randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            rd  = 1'($urandom_range(0, 1));
            blk = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 127)) : 10'($urandom_range(0, 1023));
            wd  = {$urandom, $urandom, $urandom, $urandom};
            do_txn(rd, blk, a, wd, $sformatf("rand%0d", i), rdo, tco);
            model_apply(rd, blk, a, wd);
            chk($sformatf("rand%0d rdata", i), rdo, mrd);
            chk($sformatf("rand%0d txn", i), 128'(tco), 128'(mtxn));
        end

        // LATENCY=1 instance: back-to-back reads with memReq held high
        req1 = 1'b1; rd1 = 1'b1; addr1 = 10'h040;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) addr1 = 10'h050;
            if (k == 3) req1 = 1'b0;
            chk1($sformatf("lat1 done k=%0d", k), done1, (k % 3) == 1);
            chk1($sformatf("lat1 busy k=%0d", k), busy1, (k % 3) != 2);
            if (k == 1) chk("lat1 first rdata", rdata1, {32'd16, 32'd17, 32'd18, 32'd19});
            if (k == 4) begin
                chk("lat1 second rdata", rdata1, {32'd20, 32'd21, 32'd22, 32'd23});
                chk("lat1 txn", 128'(txn1), 128'd2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
